// File: rtl/bus_slave_mem.sv
// Word-addressed slave memory for the crossbar request bus, with a fixed or
// LFSR-driven pseudo-random wait-state generator in front of the ack.
module bus_slave_mem #(
  parameter int         N         = 32,
  parameter int         AW        = 8,
  parameter int         WAIT      = 0,
  parameter int         WAIT_MODE = 0,
  parameter logic [3:0] SEED      = 4'b0001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [N-1:0] addr,
  input  logic         cmd,
  input  logic [N-1:0] wdata,
  output logic         ack,
  output logic [N-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_WAIT,
    PH_ACK
  } phase_e;

  logic [2:0]   cnt_q, cnt_d;
  logic [3:0]   lfsr_q, lfsr_d;
  logic [N-1:0] rdata_q;
  logic [N-1:0] mem_q [DEPTH];
  logic [2:0]   cur_wait;
  logic [AW-1:0] idx;
  phase_e       phase;
  logic         unused_addr_hi;

  // Slave select is decoded upstream, so only the low index bits matter here.
  assign idx            = addr[AW-1:0];
  assign unused_addr_hi = ^addr[N-1:AW];

  assign cur_wait = (WAIT_MODE != 0) ? {1'b0, lfsr_q[1:0]} : 3'(WAIT);

  // The phase is a pure decode of the wait counter and req; cnt is the state.
  always_comb begin
    phase = PH_IDLE;
    if (req) begin
      phase = (cnt_q == cur_wait) ? PH_ACK : PH_WAIT;
    end
  end

  // Gating with reset keeps ack low while reset is asserted, even with zero waits.
  assign ack   = reset && (phase == PH_ACK);
  assign rdata = rdata_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    unique case (phase)
      PH_IDLE: cnt_d = 3'd0;
      PH_WAIT: begin
        if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
      end
      PH_ACK: begin
        cnt_d = 3'd0;
        if (WAIT_MODE != 0) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      end
      default: cnt_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      cnt_q   <= 3'd0;
      lfsr_q  <= SEED;
      rdata_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      if (ack && !cmd) rdata_q <= mem_q[idx];
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (ack && cmd) mem_q[idx] <= wdata;
  end

`ifndef SYNTHESIS
  a_req_held: assert property (@(posedge clk) disable iff (!reset)
    (req && !ack && cnt_q != 3'd0) |=> req)
    else $warning("bus_slave_mem: req dropped while waiting for ack");

  a_seed_nonzero: assert property (@(posedge clk) SEED != 4'b0000)
    else $error("bus_slave_mem: SEED must be nonzero");
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Randomized bench for bus_slave_mem: four instances (WAIT 0/2/3 and LFSR mode)
// checked against a transaction-level latency model and a memory scoreboard.
module tb_bus_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  cmd;
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  wire  [3:0]  ack;
  wire  [31:0] rdata [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_m  [4][16];
  logic [31:0] exp_rd [4];
  int          lfsr_m = 1;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_slave_mem #(.N(32), .AW(8), .WAIT(0), .WAIT_MODE(0), .SEED(4'b0001)) u_w0 (
    .clk(clk), .reset(reset), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]));
  bus_slave_mem #(.N(32), .AW(8), .WAIT(2), .WAIT_MODE(0), .SEED(4'b0001)) u_w2 (
    .clk(clk), .reset(reset), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]));
  bus_slave_mem #(.N(32), .AW(8), .WAIT(3), .WAIT_MODE(0), .SEED(4'b0001)) u_w3 (
    .clk(clk), .reset(reset), .req(req[2]), .addr(addr[2]), .cmd(cmd[2]),
    .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]));
  bus_slave_mem #(.N(32), .AW(8), .WAIT(0), .WAIT_MODE(1), .SEED(4'b0001)) u_rnd (
    .clk(clk), .reset(reset), .req(req[3]), .addr(addr[3]), .cmd(cmd[3]),
    .wdata(wdata[3]), .ack(ack[3]), .rdata(rdata[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int v);
    return ((v << 1) & 15) | (((v >> 3) ^ (v >> 2)) & 1);
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return lfsr_m & 3;
    endcase
  endfunction

  // Scoreboard: commits accepted writes, predicts rdata, checks it holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!reset) begin
          exp_rd[i] = '0;
          check($sformatf("rdata_in_reset%0d", i), rdata[i], 32'h0);
        end else begin
          check($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
          if (req[i] && ack[i]) begin
            if (cmd[i]) mem_m[i][addr[i][3:0]] = wdata[i];
            else        exp_rd[i] = mem_m[i][addr[i][3:0]];
          end
        end
      end
    end
  end

  // One request: junk on addr/cmd/wdata while waiting, real values in the ack cycle.
  task automatic txn(input int i, input bit c, input logic [3:0] idx, input logic [31:0] d,
                     input bit keep, input bit junk, input int lat_ovr = -1);
    int lat;
    logic [31:0] a;
    lat = (lat_ovr >= 0) ? lat_ovr : lat_of(i);
    req[i] = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      if (junk && k < lat) begin
        cmd[i]   = 1'($urandom);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
      end else begin
        a        = $urandom;
        a[7:0]   = {4'h0, idx};
        cmd[i]   = c;
        addr[i]  = a;
        wdata[i] = d;
      end
      @(negedge clk);
      check($sformatf("ack%0d_cyc%0d", i, k), {31'b0, ack[i]}, {31'b0, (k == lat)});
      @(posedge clk); #1;
    end
    if (i == 3) lfsr_m = lfsr_next(lfsr_m);
    if (!keep) req[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          lfsr_tbl [4];
    lfsr_tbl = '{1, 2, 0, 1};

    reset = 1'b0;
    req   = '0;
    cmd   = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i]   = '0;
      wdata[i]  = '0;
      exp_rd[i] = '0;
    end
    mon_en = 1'b1;

    // Reset state: ack stays low even with req high and zero waits
    req[0] = 1'b1;
    #12;
    @(negedge clk);
    check("ack_in_reset", {31'b0, ack[0]}, 32'h0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // LFSR mode from SEED=0001: wait states 1, 2, 0, 1
    for (int j = 0; j < 4; j++) txn(3, 1'b1, 4'(j), $urandom, 1'b1, 1'b1, lfsr_tbl[j]);
    req[3] = 1'b0;
    idle(1);

    // Preload the 16 indices used by every instance
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) txn(i, 1'b1, 4'(k), $urandom, 1'(($urandom % 2)), 1'b1);
    req = '0;
    idle(2);

    // WAIT=0 write then read idx 5
    txn(0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1);
    txn(0, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("w0_read5", rdata[0], 32'hDEADBEEF);
    idle(1);

    // WAIT=2 read idx 9
    txn(1, 1'b0, 4'd9, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("w2_read9", rdata[1], mem_m[1][9]);
    idle(1);

    // WAIT=2 abort: write attempt held one cycle, then dropped
    txn(1, 1'b1, 4'd3, 32'h0BADF00D, 1'b0, 1'b0);
    idle(1);
    req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h3; wdata[1] = 32'h1234;
    @(negedge clk);
    check("abort_ack", {31'b0, ack[1]}, 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    idle(1);
    txn(1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_mem_unchanged", rdata[1], 32'h0BADF00D);
    idle(1);

    // WAIT=0 back-to-back reads, then read-after-write on consecutive acks
    txn(0, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'd2, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0);
    idle(1);
    v = $urandom;
    txn(0, 1'b1, 4'd7, v, 1'b1, 1'b0);
    txn(0, 1'b0, 4'd7, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("raw_idx7", rdata[0], v);
    idle(1);

    // Random traffic across all instances
    for (int n = 0; n < 200; n++) begin
      int i;
      bit keep;
      i    = int'($urandom % 4);
      keep = 1'($urandom % 2);
      txn(i, 1'($urandom % 2), 4'($urandom % 16), $urandom, keep, 1'b1);
      req[i] = 1'b0;
      if (!keep || ($urandom % 3 == 0)) idle(int'($urandom % 3));
    end
    req = '0;
    idle(2);

    // Reset during WAITING on the WAIT=3 instance at cnt=2
    req[2] = 1'b1; cmd[2] = 1'b0; addr[2] = 32'h4;
    repeat (2) begin
      @(negedge clk);
      check("prereset_ack", {31'b0, ack[2]}, 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("reset_ack_drop", {31'b0, ack[2]}, 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
    lfsr_m = 1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    reset  = 1'b1;
    idle(1);
    txn(2, 1'b0, 4'd4, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_read4", rdata[2], mem_m[2][4]);
    idle(1);
    txn(3, 1'b0, 4'd6, 32'h0, 1'b0, 1'b0, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
- Slave-side responder for the crossbar's master/slave request bus: req/addr/cmd/wdata in, ack/rdata out.
- Contains a word-addressed memory and a wait-state generator, so one instance can sit on each crossbar slave port.
- Supports fixed and pseudo-random ack latency to stress crossbar arbitration and the masters' ack-time checks.
- Used as the standard slave model in crossbar testbenches and as a synthesizable scratch RAM.

Parameters:
- N, 32, bus data/address width.
- AW, 8, memory index width; depth = 2**AW words of N bits.
- WAIT, 0, fixed wait states before ack (0..7); used when WAIT_MODE=0.
- WAIT_MODE, 0, 0 = fixed latency WAIT; 1 = pseudo-random latency 0..3 from LFSR.
- SEED, 4'b0001, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request; held high by the requester until ack.
- addr  input  N  address; word index = addr[AW-1:0]; upper bits ignored (slave select is done upstream).
- cmd  input  1  0 = read, 1 = write.
- wdata  input  N  write data; sampled in the ack cycle.
- ack  output  1  single-cycle accept strobe, combinational from req and internal state.
- rdata  output  N  read data, valid in the cycle after a read ack; holds its value otherwise.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset.
- Reset values: cnt = 0, lfsr = SEED, rdata = 0, ack = 0 while reset is low. Memory contents are not reset.
- Wait select: cur_wait = (WAIT_MODE ? {1'b0, lfsr[1:0]} : WAIT), 3 bits wide.
- ack = req && (cnt == cur_wait). With cur_wait = 0, ack is asserted in the same cycle as req.
- Counter cnt (3 bits, saturates at 7):
  - if !req, cnt <= 0;
  - else if ack, cnt <= 0;
  - else cnt <= cnt + 1.
- FSM view:
  - IDLE (cnt == 0, no req held).
  - WAITING (req held, cnt < cur_wait).
  - ACK cycle: returns to IDLE, or restarts immediately if req stays high.
- Write: on a posedge with req && ack && cmd, mem[addr[AW-1:0]] <= wdata.
- Read: on a posedge with req && ack && !cmd, rdata <= mem[addr[AW-1:0]]. rdata is therefore valid exactly one cycle after ack.
- Back-to-back: if req stays high after an ack, the next transaction starts counting immediately. With WAIT=0 this gives one ack per cycle and fully pipelined reads.
- Abort: req dropped before ack means no memory access, rdata unchanged, cnt = 0 next cycle, LFSR unchanged.
- LFSR (4-bit Fibonacci, x^4+x^3+1): lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]}. Steps only on cycles with req && ack, and only when WAIT_MODE = 1.
- Read-after-write to the same index on consecutive acks returns the new data (the write commits at the earlier edge).
- Inputs addr, cmd and wdata need only be stable in the ack cycle. Changes during WAITING do not restart the count.
- Reset mid-wait: ack drops immediately, state returns to reset values, and the pending access is discarded.
- Assertion (sim only): req must not fall in a cycle where ack was low and cnt > 0 unless the requester aborts; flag a warning. Also error if SEED == 0.

Test Plan:
- WAIT=0: write idx 5 = 0xDEADBEEF (cmd=1), then read idx 5 -> ack in the same cycle as each req; rdata = 0xDEADBEEF one cycle after the read ack.
- WAIT=2: read idx 9 with req held from cycle 0 -> ack low in cycles 0 and 1, high in cycle 2; rdata valid in cycle 3.
- WAIT=2 abort: write idx 3 = 0x1234, req high 1 cycle then low -> no ack and idx 3 unchanged. Next request again waits 2 cycles before ack.
- WAIT=0 back-to-back: reads of idx 1, 2, 3 on three consecutive cycles with req held -> ack high all 3 cycles; rdata returns mem[1], mem[2], mem[3] in the following 3 cycles.
- WAIT_MODE=1, SEED=4'b0001: four consecutive requests -> wait states 1, 2, 0, 1 (lfsr 0001 -> 0010 -> 0100 -> 1001).
- Reset asserted during WAITING (WAIT=3, cnt=2) -> ack = 0, rdata = 0, lfsr = SEED immediately. After release, a new req needs the full 3 waits.
